// File: rtl/aes_masking_pkg.sv
// ----------------------------------------------------------------------------
// aes_masking_pkg: S-box table, PRNG constants, random-bus widths. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package aes_masking_pkg;

  localparam logic [31:0] c_lfsr_poly     = 32'h8020_0003;
  localparam logic [31:0] c_lfsr_seed_mul = 32'h9E37_79B9;
  localparam logic [31:0] c_default_seed  = 32'h1ACE_B00C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
  } pipe_t;

  // Entry 0 sits in the most significant byte.
  localparam logic [2047:0] c_sbox_flat = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return c_sbox_flat[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? c_lfsr_poly : 32'h0);
  endfunction

  function automatic int unsigned zmul1_w(input int unsigned s);
    return 4 * s * (s - 1);
  endfunction

  function automatic int unsigned zmul23_w(input int unsigned s);
    return 2 * s * (s - 1);
  endfunction

  function automatic int unsigned zinv_w(input int unsigned s);
    return s * (s - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sbox_selftest_ctrl_if.sv
// ----------------------------------------------------------------------------
// sbox_selftest_ctrl_if: masked data and randomness link to aes_sbox. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface sbox_selftest_ctrl_if
  import aes_masking_pkg::*;
#(
  parameter int unsigned SHARES  = 2,
  parameter int unsigned BLIND_W = 8
);

  logic [8*SHARES-1:0]           XxDO;
  logic [8*SHARES-1:0]           QxDI;
  logic [zmul1_w(SHARES)-1:0]    Zmul1xDO;
  logic [zmul23_w(SHARES)-1:0]   Zmul2xDO;
  logic [zmul23_w(SHARES)-1:0]   Zmul3xDO;
  logic [zinv_w(SHARES)-1:0]     Zinv1xDO;
  logic [zinv_w(SHARES)-1:0]     Zinv2xDO;
  logic [zinv_w(SHARES)-1:0]     Zinv3xDO;
  logic [BLIND_W-1:0]            BxDO;

  modport master (
    output XxDO, Zmul1xDO, Zmul2xDO, Zmul3xDO, Zinv1xDO, Zinv2xDO, Zinv3xDO, BxDO,
    input  QxDI
  );

  modport slave (
    input  XxDO, Zmul1xDO, Zmul2xDO, Zmul3xDO, Zinv1xDO, Zinv2xDO, Zinv3xDO, BxDO,
    output QxDI
  );

endinterface

`default_nettype wire

// File: rtl/sbox_selftest_ctrl_lfsr32_bank.sv
// ----------------------------------------------------------------------------
// lfsr32_bank: NUM independently seeded 32-bit Galois LFSRs. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr32_bank
  import aes_masking_pkg::*;
#(
  parameter int unsigned NUM  = 1,
  parameter logic [31:0] SEED = c_default_seed
) (
  input  logic              ClkxCI,
  input  logic              RstxBI,
  input  logic              LoadxSI,
  input  logic              StepxSI,
  output logic [32*NUM-1:0] WordxDO
);

  for (genvar k = 0; k < NUM; k++) begin : g_lfsr
    localparam logic [31:0] c_seed = SEED ^ (32'(k) * c_lfsr_seed_mul);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
      lfsr_d = lfsr_q;
      if (LoadxSI) begin
        lfsr_d = c_seed;
      end else if (StepxSI) begin
        lfsr_d = lfsr_next(lfsr_q);
      end
    end

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        lfsr_q <= c_seed;
      end else begin
        lfsr_q <= lfsr_d;
      end
    end

    assign WordxDO[32*k +: 32] = lfsr_q;
  end

endmodule

`default_nettype wire

// File: rtl/sbox_selftest_ctrl.sv
// ----------------------------------------------------------------------------
// sbox_selftest_ctrl: masked stimulus driver and checker for aes_sbox. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sbox_selftest_ctrl
  import aes_masking_pkg::*;
#(
  parameter int unsigned SHARES  = 2,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned BLIND_W = 8,
  parameter int unsigned RND_W   = SHARES * (SHARES - 1) * 11 + BLIND_W,
  parameter logic [31:0] SEED    = c_default_seed
) (
  input  logic                 ClkxCI,
  input  logic                 RstxBI,
  input  logic                 StartxSI,
  output logic                 BusyxSO,
  output logic                 DonexSO,
  output logic                 PassxSO,
  output logic [8:0]           ErrCntxDO,
  output logic [7:0]           FirstErrxDO,
  sbox_selftest_ctrl_if.master sbox
);

  localparam int unsigned c_mask_w = 8 * (SHARES - 1);
  localparam int unsigned c_num    = (c_mask_w + RND_W + 31) / 32;
  localparam int unsigned c_zm1    = zmul1_w(SHARES);
  localparam int unsigned c_zm23   = zmul23_w(SHARES);
  localparam int unsigned c_zi     = zinv_w(SHARES);
  localparam int unsigned c_o_zm1  = c_mask_w;
  localparam int unsigned c_o_zm2  = c_o_zm1 + c_zm1;
  localparam int unsigned c_o_zm3  = c_o_zm2 + c_zm23;
  localparam int unsigned c_o_zi1  = c_o_zm3 + c_zm23;
  localparam int unsigned c_o_zi2  = c_o_zi1 + c_zi;
  localparam int unsigned c_o_zi3  = c_o_zi2 + c_zi;
  localparam int unsigned c_o_b    = c_o_zi3 + c_zi;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [8:0]  err_q, err_d;
  logic [7:0]  first_q, first_d;
  logic        pass_q, pass_d;
  pipe_t       pipe_q [LATENCY];
  pipe_t       pipe_d [LATENCY];

  logic [32*c_num-1:0] w_rnd;
  logic                w_rnd_unused;
  logic                w_rnd_en;
  logic                w_load;
  logic                w_hit;
  logic [7:0]          w_q;
  logic [7:0]          w_sh0;
  logic [8*SHARES-1:0] w_x;
  pipe_t               w_pipe_out;

  lfsr32_bank #(
    .NUM  (c_num),
    .SEED (SEED)
  ) u_prng (
    .ClkxCI  (ClkxCI),
    .RstxBI  (RstxBI),
    .LoadxSI (w_load),
    .StepxSI (w_rnd_en),
    .WordxDO (w_rnd)
  );

  // Bits beyond the consumed slices exist only because the bank is word sized.
  assign w_rnd_unused = ^w_rnd;

  assign w_rnd_en   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign w_pipe_out = pipe_q[LATENCY-1];

  always_comb begin
    w_x   = '0;
    w_sh0 = cnt_q;
    for (int j = 1; j < SHARES; j++) begin
      w_x[8*j +: 8] = w_rnd[8*(j-1) +: 8];
      w_sh0         = w_sh0 ^ w_rnd[8*(j-1) +: 8];
    end
    w_x[7:0] = w_sh0;
    if (state_q != ST_RUN) begin
      w_x = '0;
    end
  end

  assign sbox.XxDO     = w_x;
  assign sbox.Zmul1xDO = w_rnd_en ? w_rnd[c_o_zm1 +: c_zm1]  : '0;
  assign sbox.Zmul2xDO = w_rnd_en ? w_rnd[c_o_zm2 +: c_zm23] : '0;
  assign sbox.Zmul3xDO = w_rnd_en ? w_rnd[c_o_zm3 +: c_zm23] : '0;
  assign sbox.Zinv1xDO = w_rnd_en ? w_rnd[c_o_zi1 +: c_zi]   : '0;
  assign sbox.Zinv2xDO = w_rnd_en ? w_rnd[c_o_zi2 +: c_zi]   : '0;
  assign sbox.Zinv3xDO = w_rnd_en ? w_rnd[c_o_zi3 +: c_zi]   : '0;
  assign sbox.BxDO     = w_rnd_en ? w_rnd[c_o_b   +: BLIND_W] : '0;

  always_comb begin
    w_q = '0;
    for (int j = 0; j < SHARES; j++) begin
      w_q = w_q ^ sbox.QxDI[8*j +: 8];
    end
  end

  assign w_hit = w_pipe_out.valid && (w_q != sbox_lookup(w_pipe_out.tag));

  // The tag pipe mirrors the S-box latency so each result meets its own input.
  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      pipe_d[k] = '0;
    end
    if (!w_load) begin
      for (int k = LATENCY - 1; k > 0; k--) begin
        pipe_d[k] = pipe_q[k-1];
      end
      if (state_q == ST_RUN) begin
        pipe_d[0].valid = 1'b1;
        pipe_d[0].tag   = cnt_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;
    w_load  = 1'b0;

    if (w_hit) begin
      err_d = err_q + 9'd1;
      if (err_q == 9'd0) begin
        first_d = w_pipe_out.tag;
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (StartxSI) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          w_load  = 1'b1;
        end
      end
      ST_RUN: begin
        // Wraps to 0 on the last value, which then serves as the drain counter.
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'hFF) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(LATENCY - 1)) begin
          state_d = ST_DONE;
          pass_d  = (err_d == 9'd0);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign BusyxSO     = w_rnd_en;
  assign DonexSO     = (state_q == ST_DONE);
  assign PassxSO     = pass_q;
  assign ErrCntxDO   = err_q;
  assign FirstErrxDO = first_q;

endmodule

`default_nettype wire

// File: tb/tb_sbox_selftest_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sbox_selftest_ctrl: directed runs against a behavioural masked S-box. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sbox_selftest_ctrl;
  import aes_masking_pkg::*;

  localparam int NCFG = 3;
  localparam int LAT  = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NCFG-1:0] start, busy_a, done_a, pass_a;
  logic [8:0]      errc_a [NCFG];
  logic [7:0]      ferr_a [NCFG];
  logic [7:0]      xr_a   [NCFG];
  logic [7:0]      qr_a   [NCFG];
  logic [31:0]     xlow_a [NCFG];
  logic            fault_53;
  logic            extra_dly;
  logic [7:0]      sbox_ref [256];
  logic [7:0]      sh1_log  [256];

  int checks   = 0;
  int failures = 0;

  // Reference S-box built from GF(2^8) inversion and the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = '0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] x);
    logic [7:0] inv;
    inv = '0;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  for (genvar k = 0; k < NCFG; k++) begin : g_cfg
    localparam int          SH = k + 2;
    localparam logic [31:0] SD = (k == 2) ? 32'h1234_5678 : 32'h1ACE_B00C;

    sbox_selftest_ctrl_if #(.SHARES(SH), .BLIND_W(8)) bus ();

    sbox_selftest_ctrl #(
      .SHARES(SH), .LATENCY(LAT), .BLIND_W(8), .SEED(SD)
    ) dut (
      .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start[k]),
      .BusyxSO(busy_a[k]), .DonexSO(done_a[k]), .PassxSO(pass_a[k]),
      .ErrCntxDO(errc_a[k]), .FirstErrxDO(ferr_a[k]), .sbox(bus)
    );

    logic [8*SH-1:0] dly [LAT+1];
    logic [7:0]      xr, qr;

    always_comb begin
      xr = '0;
      qr = '0;
      for (int j = 0; j < SH; j++) begin
        xr = xr ^ bus.XxDO[8*j +: 8];
        qr = qr ^ bus.QxDI[8*j +: 8];
      end
    end

    // Masked S-box model: idle input cycles yield all-zero shares.
    always @(posedge clk) begin : p_model
      logic [8*SH-1:0] o;
      o = '0;
      if (busy_a[k]) begin
        o[7:0] = sbox_ref[xr];
        for (int j = 1; j < SH; j++) begin
          o[8*j +: 8] = 8'($urandom);
          o[7:0]      = o[7:0] ^ o[8*j +: 8];
        end
        if (k == 0 && fault_53 && xr == 8'h53) o[0] = ~o[0];
      end
      dly[0] <= o;
      for (int m = 1; m <= LAT; m++) dly[m] <= dly[m-1];
    end

    assign bus.QxDI  = (k == 0 && extra_dly) ? dly[LAT] : dly[LAT-1];
    assign xr_a[k]   = xr;
    assign qr_a[k]   = qr;
    assign xlow_a[k] = 32'(bus.XxDO);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // logmode: 0 none, 1 record share 1 per value, 2 compare against the record.
  task automatic run_once(input int k, input bit pulses, input int rst_at, input bit spot,
                          input int logmode, output int ncyc, output logic [31:0] xfirst);
    int n, bad, diff;
    bad = 0; diff = 0; xfirst = '0;
    start[k] = 1'b1;
    tick();
    n = 1;
    start[k] = 1'b0;
    while (done_a[k] !== 1'b1 && n < 400) begin
      if (n <= 256) begin
        if (xr_a[k] !== 8'(n - 1)) bad++;
        if (logmode == 1) sh1_log[n-1] = xlow_a[k][15:8];
        if (logmode == 2 && sh1_log[n-1] !== xlow_a[k][15:8]) diff++;
      end
      if (n == 1) xfirst = xlow_a[k];
      if (spot && n == 5)        chk("q_i00", qr_a[k], 8'h63);
      if (spot && n == 6)        chk("q_i01", qr_a[k], 8'h7C);
      if (spot && n == 8'h53 + 5) chk("q_i53", qr_a[k], 8'hED);
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_a[k], 0);
        chk("midrst_done", done_a[k], 0);
        chk("midrst_pass", pass_a[k], 0);
        chk("midrst_errc", errc_a[k], 0);
        chk("midrst_ferr", ferr_a[k], 0);
        chk("midrst_x",    xlow_a[k], 0);
        chk("midrst_xrec", bad, 0);
        ncyc = n;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (pulses) start[k] = (n == 100 || n == 258);
      tick();
      n++;
    end
    start[k] = 1'b0;
    chk("xrec_run", bad, 0);
    if (logmode == 2) chk("sh1_repeat", diff, 0);
    ncyc = n;
  endtask

  initial begin
    int          ncyc;
    logic [31:0] xf;
    for (int v = 0; v < 256; v++) sbox_ref[v] = sbox_math(8'(v));
    rst_n = 1'b0; start = '0; fault_53 = 1'b0; extra_dly = 1'b0;
    tick(); tick();

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_errc", errc_a[0], 0);
    chk("rst_ferr", ferr_a[0], 0);
    chk("rst_x",    xlow_a[0], 0);
    chk("rst_z",    32'(g_cfg[0].bus.Zmul1xDO), 0);
    rst_n = 1'b1;
    tick();

    run_once(0, 1'b0, -1, 1'b1, 1, ncyc, xf);
    chk("clean_cycles", ncyc, 261);
    chk("clean_pass", pass_a[0], 1);
    chk("clean_errc", errc_a[0], 0);
    chk("clean_ferr", ferr_a[0], 0);
    chk("seed_sh1",   xf[15:8], 8'h0C);
    tick(); tick();
    chk("done_hold",  done_a[0], 1);

    fault_53 = 1'b1;
    run_once(0, 1'b0, -1, 1'b0, 0, ncyc, xf);
    fault_53 = 1'b0;
    chk("flt_errc", errc_a[0], 1);
    chk("flt_ferr", ferr_a[0], 8'h53);
    chk("flt_pass", pass_a[0], 0);

    extra_dly = 1'b1;
    run_once(0, 1'b0, -1, 1'b0, 0, ncyc, xf);
    extra_dly = 1'b0;
    chk("dly_errc", errc_a[0], 256);
    chk("dly_ferr", ferr_a[0], 8'h00);
    chk("dly_pass", pass_a[0], 0);

    run_once(0, 1'b1, -1, 1'b0, 0, ncyc, xf);
    chk("pulse_cycles", ncyc, 261);
    chk("pulse_pass", pass_a[0], 1);
    chk("pulse_errc", errc_a[0], 0);

    run_once(0, 1'b0, 8'h80 + 1, 1'b0, 0, ncyc, xf);
    tick();
    chk("post_rst_idle", {busy_a[0], done_a[0]}, 0);
    run_once(0, 1'b0, -1, 1'b1, 2, ncyc, xf);
    chk("rerun_cycles", ncyc, 261);
    chk("rerun_pass", pass_a[0], 1);
    chk("rerun_errc", errc_a[0], 0);

    run_once(1, 1'b1, -1, 1'b1, 0, ncyc, xf);
    chk("s3_cycles", ncyc, 261);
    chk("s3_pass", pass_a[1], 1);
    chk("s3_errc", errc_a[1], 0);
    chk("s3_seed", xf[23:8], 16'hB00C);

    run_once(2, 1'b0, -1, 1'b1, 0, ncyc, xf);
    chk("s4_cycles", ncyc, 261);
    chk("s4_pass", pass_a[2], 1);
    chk("s4_errc", errc_a[2], 0);
    chk("s4_seed", xf[31:8], 24'h345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
